// File: rtl/wb_select_pkg.sv
// Shared definitions for the write-back selector: state encoding and counter sizing.
package wb_select_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_WAIT  = 2'd1;
  localparam logic [STATE_W-1:0] S_WRITE = 2'd2;

  // Wait counter must hold values 0..timeout-1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/wb_src_mux.sv
// Combinational NUM_SRC:1 result-source mux with ready and selector-range flags.
module wb_src_mux #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned SEL_W   = 3
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [NUM_SRC-1:0]       src_ready,
  output logic [WIDTH-1:0]         data_sel,
  output logic                     ready_sel,
  output logic                     sel_valid
);

  // Out-of-range selectors yield zero data and no ready.
  always_comb begin
    data_sel  = '0;
    ready_sel = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data_sel  = data_in[i*WIDTH +: WIDTH];
        ready_sel = src_ready[i];
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_select_seq.sv
// Sequenced write-back selector: waits for the chosen source, registers its data
// and issues a single-cycle register-file write strobe.
module wb_select_seq
  import wb_select_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [SEL_W-1:0]         selector,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [NUM_SRC-1:0]       src_ready,
  input  logic [ADDR_W-1:0]        wb_addr_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, mux_sel;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   data_d, mux_data;
  logic [ADDR_W-1:0]  addr_d;
  logic               wr_en_d, busy_d, err_d;
  logic               mux_ready, mux_valid;

  // In IDLE the live selector is decoded; afterwards the latched copy.
  assign mux_sel = (state == S_IDLE) ? selector : sel_q;

  wb_src_mux #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_mux (
    .sel       (mux_sel),
    .data_in   (data_in),
    .src_ready (src_ready),
    .data_sel  (mux_data),
    .ready_sel (mux_ready),
    .sel_valid (mux_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (req && mux_valid) state_d = mux_ready ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        if (mux_ready)             state_d = S_WRITE;
        else if (cnt == CNT_LAST)  state_d = S_IDLE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and latched selector.
  always_comb begin
    data_d = data_out;
    addr_d = wr_addr;
    sel_d  = sel_q;
    cnt_d  = cnt;
    err_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          sel_d  = selector;
          addr_d = wb_addr_in;
          if (!mux_valid)     err_d  = 1'b1;
          else if (mux_ready) data_d = mux_data;
          else                cnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (mux_ready)            data_d = mux_data;
        else if (cnt == CNT_LAST) err_d  = 1'b1;
        else                      cnt_d  = cnt + CNT_W'(1);
      end
      default: ;
    endcase
    // Register 0 is hardwired to zero, so its write is dropped.
    wr_en_d = (state_d == S_WRITE) && (addr_d != '0);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      wr_addr  <= '0;
      sel_q    <= '0;
      cnt      <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      data_out <= data_d;
      wr_addr  <= addr_d;
      sel_q    <= sel_d;
      cnt      <= cnt_d;
      wr_en    <= wr_en_d;
      busy     <= busy_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_select_seq.sv
// Directed bench for wb_select_seq with hand-computed expectations (TIMEOUT=8).
module tb_wb_select_seq;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned TIMEOUT = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req;
  logic [SEL_W-1:0]         selector;
  logic [NUM_SRC*WIDTH-1:0] data_in;
  logic [NUM_SRC-1:0]       src_ready;
  logic [ADDR_W-1:0]        wb_addr_in;
  logic [WIDTH-1:0]         data_out;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     wr_en;
  logic                     busy;
  logic                     err;

  int n_checks = 0;
  int n_fail   = 0;

  wb_select_seq #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .selector   (selector),
    .data_in    (data_in),
    .src_ready  (src_ready),
    .wb_addr_in (wb_addr_in),
    .data_out   (data_out),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] d, input logic [31:0] a,
                            input logic w, input logic b, input logic e);
    check_eq({tag, ".data"}, data_out, d);
    check_eq({tag, ".addr"}, 32'(wr_addr), a);
    check_eq({tag, ".wr_en"}, 32'(wr_en), 32'(w));
    check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    check_eq({tag, ".err"}, 32'(err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; selector = '0; data_in = '0; src_ready = '0; wb_addr_in = '0;
    step(); step();
    check_outs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    // Immediate source
    req = 1'b1; selector = 3'd2; src_ready = 6'b000100; wb_addr_in = 5'd8;
    data_in[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    step(); req = 1'b0;
    check_outs("imm.write", 32'hDEADBEEF, 32'd8, 1'b1, 1'b1, 1'b0);
    step();
    check_outs("imm.after", 32'hDEADBEEF, 32'd8, 1'b0, 1'b0, 1'b0);

    // Slow source; selector/address toggle and a non-selected ready are ignored
    req = 1'b1; selector = 3'd4; src_ready = 6'b000000; wb_addr_in = 5'd9;
    data_in[4*WIDTH +: WIDTH] = 32'h0000_1234;
    data_in[1*WIDTH +: WIDTH] = 32'h5555_5555;
    for (int i = 1; i <= 5; i++) begin
      step(); req = 1'b0;
      check_eq("slow.busy", 32'(busy), 32'd1);
      check_eq("slow.wr_en", 32'(wr_en), 32'd0);
      if (i == 5) begin
        src_ready = 6'b010000; selector = 3'd4; wb_addr_in = 5'd9;
      end else begin
        src_ready = 6'b000010; selector = 3'd1; wb_addr_in = 5'd3;
      end
    end
    step(); src_ready = '0;
    check_outs("slow.write", 32'h0000_1234, 32'd9, 1'b1, 1'b1, 1'b0);
    step();
    check_outs("slow.after", 32'h0000_1234, 32'd9, 1'b0, 1'b0, 1'b0);

    // Timeout: 8 WAIT cycles then a single err pulse
    req = 1'b1; selector = 3'd1; src_ready = '0; wb_addr_in = 5'd5;
    for (int i = 1; i <= 8; i++) begin
      step(); req = 1'b0;
      check_eq("tmo.busy", 32'(busy), 32'd1);
      check_eq("tmo.err", 32'(err), 32'd0);
      check_eq("tmo.wr_en", 32'(wr_en), 32'd0);
    end
    step();
    check_outs("tmo.abort", 32'h0000_1234, 32'd5, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("tmo.err_clear", 32'(err), 32'd0);

    // Ready arrives on the final WAIT cycle: ready beats timeout
    req = 1'b1; selector = 3'd1; wb_addr_in = 5'd5;
    data_in[1*WIDTH +: WIDTH] = 32'hABCD_0001;
    for (int i = 1; i <= 8; i++) begin
      step(); req = 1'b0;
      check_eq("last.busy", 32'(busy), 32'd1);
      if (i == 8) src_ready = 6'b000010;
    end
    step(); src_ready = '0;
    check_outs("last.write", 32'hABCD_0001, 32'd5, 1'b1, 1'b1, 1'b0);
    step();
    check_outs("last.after", 32'hABCD_0001, 32'd5, 1'b0, 1'b0, 1'b0);

    // Illegal selector
    req = 1'b1; selector = 3'd7; src_ready = '1; wb_addr_in = 5'd4;
    step(); req = 1'b0;
    check_outs("illegal", 32'hABCD_0001, 32'd4, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("illegal.after", 32'hABCD_0001, 32'd4, 1'b0, 1'b0, 1'b0);

    // Zero destination register: WRITE visited, no strobe
    req = 1'b1; selector = 3'd0; src_ready = '1; wb_addr_in = 5'd0;
    data_in[0*WIDTH +: WIDTH] = 32'h1111_0000;
    step(); req = 1'b0;
    check_outs("zero.write", 32'h1111_0000, 32'd0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("zero.after", 32'h1111_0000, 32'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with req held high
    for (int i = 0; i < NUM_SRC; i++) data_in[i*WIDTH +: WIDTH] = 32'hC0DE_0000 + 32'(i * 17);
    src_ready = '1; req = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      selector = SEL_W'(i); wb_addr_in = ADDR_W'(i + 10);
      step();
      check_outs("b2b.write", 32'hC0DE_0000 + 32'(i * 17), 32'(i + 10), 1'b1, 1'b1, 1'b0);
      selector = SEL_W'((i + 3) % NUM_SRC); wb_addr_in = 5'd31;
      step();
      check_outs("b2b.idle", 32'hC0DE_0000 + 32'(i * 17), 32'(i + 10), 1'b0, 1'b0, 1'b0);
    end
    req = 1'b0; src_ready = '0;
    step();

    // Reset mid-WAIT aborts the request
    req = 1'b1; selector = 3'd5; wb_addr_in = 5'd12;
    step(); req = 1'b0;
    step(); step();
    check_eq("rst.pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_outs("rst.async", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0; src_ready = '1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rst.no_wr", 32'(wr_en), 32'd0);
      check_eq("rst.idle", 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
